// File: rtl/fetch_req_pkg.sv
// Shared IFU types for the fetch-request sequencer: architectural constants,
// tag/block records and small address helpers.
package fetch_req_pkg;

    localparam int MXLEN = 64;
    localparam logic [MXLEN-1:0] BOOT_PC = 64'h0000_0000_8000_0000;

    // kill sits in bit 0 so a generic FIFO can mark every entry dead in place
    typedef struct packed {
        logic [MXLEN-1:0] pc;
        logic             kill;
    } fetch_tag_t;

    typedef struct packed {
        logic [MXLEN-1:0] pc;
        logic [63:0]      data;
        logic [1:0]       mask;
    } fetch_blk_t;

    function automatic logic [MXLEN-1:0] blk_addr(input logic [MXLEN-1:0] pc);
        return {pc[MXLEN-1:3], 3'b000};
    endfunction

    function automatic logic [1:0] blk_mask(input logic [MXLEN-1:0] pc);
        return pc[2] ? 2'b10 : 2'b11;
    endfunction

endpackage

// File: rtl/fetch_req_if.sv
// Bundle of the pcGen, icache and instruction-buffer signals seen by fetch_req.
interface fetch_req_if;
    import fetch_req_pkg::*;

    logic [MXLEN-1:0] i_pcGen_cPc;
    logic             i_pcRedirect_pcGen_pc_valid;
    logic             o_fetchReq_pcGen_stall;
    logic             o_fetchReq_icache_req_valid;
    logic [MXLEN-1:0] o_fetchReq_icache_req_addr;
    logic             i_icache_fetchReq_req_ready;
    logic             i_icache_fetchReq_rsp_valid;
    logic [63:0]      i_icache_fetchReq_rsp_data;
    logic             o_fetchReq_ibuf_valid;
    logic             i_ibuf_fetchReq_ready;
    logic [MXLEN-1:0] o_fetchReq_ibuf_pc;
    logic [63:0]      o_fetchReq_ibuf_data;
    logic [1:0]       o_fetchReq_ibuf_mask;

    modport master (
        input  i_pcGen_cPc, i_pcRedirect_pcGen_pc_valid, i_icache_fetchReq_req_ready,
               i_icache_fetchReq_rsp_valid, i_icache_fetchReq_rsp_data, i_ibuf_fetchReq_ready,
        output o_fetchReq_pcGen_stall, o_fetchReq_icache_req_valid, o_fetchReq_icache_req_addr,
               o_fetchReq_ibuf_valid, o_fetchReq_ibuf_pc, o_fetchReq_ibuf_data, o_fetchReq_ibuf_mask
    );

    modport slave (
        output i_pcGen_cPc, i_pcRedirect_pcGen_pc_valid, i_icache_fetchReq_req_ready,
               i_icache_fetchReq_rsp_valid, i_icache_fetchReq_rsp_data, i_ibuf_fetchReq_ready,
        input  o_fetchReq_pcGen_stall, o_fetchReq_icache_req_valid, o_fetchReq_icache_req_addr,
               o_fetchReq_ibuf_valid, o_fetchReq_ibuf_pc, o_fetchReq_ibuf_data, o_fetchReq_ibuf_mask
    );

endinterface

// File: rtl/fetch_req_sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count, flush, and an in-place
// "mark" that sets bit 0 of every stored entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     mark,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] FULL = AW1'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != FULL) | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (mark) begin
            for (int i = 0; i < DEPTH; i++) mem[i][0] <= 1'b1;
        end
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fetch_req.sv
// Fetch-request sequencer: turns pcGen's PC into in-order icache requests,
// kills wrong-path responses on redirect and queues blocks for the ibuf.
module fetch_req
    import fetch_req_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input logic         i_clk,
    input logic         i_rstn,
    fetch_req_if.master bus
);

    localparam int CW  = $clog2(MAX_OUTST) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] CREDITS = CW1'(MAX_OUTST);

    logic          started;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] out_count;
    logic [CW:0]   credit_used;
    fetch_tag_t    tag_wdata;
    fetch_tag_t    tag_head;
    fetch_blk_t    blk_wdata;
    fetch_blk_t    blk_head;
    logic          redirect;
    logic          req_valid;
    logic          accept;
    logic          tag_pop;
    logic          out_push;
    logic          out_pop;
    logic          ibuf_valid;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) started <= 1'b0;
        else         started <= 1'b1;
    end

    // Credit check uses registered occupancy only: a response this cycle
    // does not free a slot for a request this cycle.
    assign redirect    = bus.i_pcRedirect_pcGen_pc_valid;
    assign credit_used = {1'b0, tag_count} + {1'b0, out_count};
    assign req_valid   = started & (credit_used < CREDITS) & ~redirect;
    assign accept      = req_valid & bus.i_icache_fetchReq_req_ready;

    assign tag_wdata = '{pc: bus.i_pcGen_cPc, kill: 1'b0};
    assign tag_pop   = bus.i_icache_fetchReq_rsp_valid & (tag_count != '0);

    sync_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (accept),
        .wdata (tag_wdata),
        .pop   (tag_pop),
        .flush (1'b0),
        .mark  (redirect),
        .rdata (tag_head),
        .count (tag_count)
    );

    // A response racing a redirect is wrong-path even if its tag is still live.
    assign out_push  = tag_pop & ~tag_head.kill & ~redirect;
    assign blk_wdata = '{pc:   tag_head.pc,
                         data: bus.i_icache_fetchReq_rsp_data,
                         mask: blk_mask(tag_head.pc)};
    assign ibuf_valid = (out_count != '0);
    assign out_pop    = ibuf_valid & bus.i_ibuf_fetchReq_ready;

    sync_fifo #(.WIDTH($bits(fetch_blk_t)), .DEPTH(MAX_OUTST)) u_out_queue (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (out_push),
        .wdata (blk_wdata),
        .pop   (out_pop),
        .flush (redirect),
        .mark  (1'b0),
        .rdata (blk_head),
        .count (out_count)
    );

    assign bus.o_fetchReq_pcGen_stall      = ~accept & ~redirect;
    assign bus.o_fetchReq_icache_req_valid = req_valid;
    assign bus.o_fetchReq_icache_req_addr  = req_valid ? blk_addr(bus.i_pcGen_cPc) : '0;
    assign bus.o_fetchReq_ibuf_valid       = ibuf_valid;
    assign bus.o_fetchReq_ibuf_pc          = ibuf_valid ? blk_head.pc   : '0;
    assign bus.o_fetchReq_ibuf_data        = ibuf_valid ? blk_head.data : '0;
    assign bus.o_fetchReq_ibuf_mask        = ibuf_valid ? blk_head.mask : '0;

    a_no_stall_on_redirect: assert property (@(posedge i_clk) disable iff (!i_rstn)
        redirect |-> !bus.o_fetchReq_pcGen_stall);
    a_no_req_without_credit: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (credit_used == CREDITS) |-> !req_valid);
    a_rsp_has_tag: assert property (@(posedge i_clk) disable iff (!i_rstn)
        bus.i_icache_fetchReq_rsp_valid |-> (tag_count != '0));

endmodule

// File: tb/tb_fetch_req.sv
// Bench for fetch_req: pcGen and icache stand-ins plus a queue-based reference
// of outstanding requests and deliverable blocks.
module tb_fetch_req;
    import fetch_req_pkg::*;

    localparam int MAX = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fetch_req_if bus();
    fetch_req #(.MAX_OUTST(MAX)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

    typedef struct { logic [63:0] pc; bit kill; } ot_t;
    typedef struct { logic [63:0] pc; logic [63:0] data; logic [1:0] mask; } eb_t;
    typedef struct { int due; logic [63:0] data; } cr_t;

    ot_t         outst[$];
    eb_t         expq[$];
    cr_t         sched[$];
    logic [63:0] acc_log[$];
    logic [63:0] dlv_pc[$];
    logic [1:0]  dlv_mask[$];

    int n_cmp = 0, n_fail = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    bit          started = 1'b0;
    logic [63:0] cpc = BOOT_PC;
    logic        obs_rv, obs_stall, obs_ibv;
    logic [63:0] obs_addr;

    // One clock of stimulus, checking and reference update; entered and left just after negedge.
    task automatic step(input bit rdy, input bit redir, input logic [63:0] tgt, input bit ibrdy);
        bit rsp, exp_rv, exp_acc, exp_stall;
        logic [63:0] rdata, ea;
        ot_t h; eb_t b; cr_t c; int due;
        rsp   = (sched.size() > 0) && (sched[0].due == cyc);
        rdata = rsp ? sched[0].data : {$urandom, $urandom};
        bus.i_pcGen_cPc                 = cpc;
        bus.i_pcRedirect_pcGen_pc_valid = redir;
        bus.i_icache_fetchReq_req_ready = rdy;
        bus.i_icache_fetchReq_rsp_valid = rsp;
        bus.i_icache_fetchReq_rsp_data  = rdata;
        bus.i_ibuf_fetchReq_ready       = ibrdy;
        #1;
        exp_rv    = started && (outst.size() + expq.size() < MAX) && !redir;
        exp_acc   = exp_rv && rdy;
        exp_stall = !exp_acc && !redir;
        ea        = {cpc[63:3], 3'b000};
        obs_rv    = bus.o_fetchReq_icache_req_valid;
        obs_stall = bus.o_fetchReq_pcGen_stall;
        obs_addr  = bus.o_fetchReq_icache_req_addr;
        obs_ibv   = bus.o_fetchReq_ibuf_valid;
        n_cmp++;
        if (obs_rv !== exp_rv) begin
            n_fail++; $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, obs_rv, exp_rv);
        end
        n_cmp++;
        if (obs_stall !== exp_stall) begin
            n_fail++; $display("FAIL stall cyc=%0d got=%b want=%b", cyc, obs_stall, exp_stall);
        end
        if (exp_rv) begin
            n_cmp++;
            if (obs_addr !== ea) begin
                n_fail++; $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, obs_addr, ea);
            end
        end
        n_cmp++;
        if (obs_ibv !== (expq.size() != 0)) begin
            n_fail++; $display("FAIL ibuf_valid cyc=%0d got=%b want=%b", cyc, obs_ibv, expq.size() != 0);
        end
        if (expq.size() != 0) begin
            n_cmp++;
            if (bus.o_fetchReq_ibuf_pc !== expq[0].pc || bus.o_fetchReq_ibuf_data !== expq[0].data ||
                bus.o_fetchReq_ibuf_mask !== expq[0].mask) begin
                n_fail++;
                $display("FAIL ibuf_blk cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc, bus.o_fetchReq_ibuf_pc,
                         bus.o_fetchReq_ibuf_data, bus.o_fetchReq_ibuf_mask, expq[0].pc, expq[0].data, expq[0].mask);
            end
        end
        if (obs_rv === 1'b1 && rdy) acc_log.push_back(obs_addr);
        if (obs_ibv === 1'b1 && ibrdy) begin
            dlv_pc.push_back(bus.o_fetchReq_ibuf_pc);
            dlv_mask.push_back(bus.o_fetchReq_ibuf_mask);
        end
        if (expq.size() != 0 && ibrdy) b = expq.pop_front();
        if (rsp) begin
            c = sched.pop_front();
            if (outst.size() != 0) begin
                h = outst.pop_front();
                if (!h.kill && !redir) begin
                    b.pc = h.pc; b.data = rdata; b.mask = h.pc[2] ? 2'b10 : 2'b11;
                    expq.push_back(b);
                end
            end
        end
        if (redir) begin
            expq.delete();
            foreach (outst[i]) outst[i].kill = 1'b1;
        end
        if (exp_acc) begin
            h.pc = cpc; h.kill = 1'b0;
            outst.push_back(h);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            c.due = due; c.data = {$urandom, $urandom};
            sched.push_back(c);
            last_due = due;
        end
        if (redir)           cpc = tgt;
        else if (!exp_stall) cpc = ea + 64'd8;
        @(posedge clk);
        cyc++;
        if (rstn) started = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        bus.i_pcGen_cPc                 = BOOT_PC;
        bus.i_pcRedirect_pcGen_pc_valid = 1'b0;
        bus.i_icache_fetchReq_req_ready = 1'b0;
        bus.i_icache_fetchReq_rsp_valid = 1'b0;
        bus.i_icache_fetchReq_rsp_data  = '0;
        bus.i_ibuf_fetchReq_ready       = 1'b0;
        outst.delete(); expq.delete(); sched.delete();
        acc_log.delete(); dlv_pc.delete(); dlv_mask.delete();
        last_due = 0; started = 1'b0; cpc = BOOT_PC;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((outst.size() != 0 || expq.size() != 0) && n < 30) begin
            step(0, 0, 0, 1); n++;
        end
        if (outst.size() != 0 || expq.size() != 0) begin
            n_cmp++; n_fail++; $display("FAIL drain_timeout cyc=%0d got=busy want=idle", cyc);
        end
        acc_log.delete(); dlv_pc.delete(); dlv_mask.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (bus.o_fetchReq_pcGen_stall !== 1'b1 || bus.o_fetchReq_icache_req_valid !== 1'b0 ||
            bus.o_fetchReq_ibuf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ctrl got stall=%b rv=%b ibv=%b want 1/0/0", tag, bus.o_fetchReq_pcGen_stall,
                     bus.o_fetchReq_icache_req_valid, bus.o_fetchReq_ibuf_valid);
        end
        n_cmp++;
        if (bus.o_fetchReq_icache_req_addr !== '0 || bus.o_fetchReq_ibuf_pc !== '0 ||
            bus.o_fetchReq_ibuf_data !== '0 || bus.o_fetchReq_ibuf_mask !== '0) begin
            n_fail++;
            $display("FAIL %s_data got addr=%h pc=%h data=%h mask=%b want zeros", tag, bus.o_fetchReq_icache_req_addr,
                     bus.o_fetchReq_ibuf_pc, bus.o_fetchReq_ibuf_data, bus.o_fetchReq_ibuf_mask);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        check_reset_outputs("reset");
        release_reset();
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1;
        repeat (16) step(1, 0, 0, 1);
        n_cmp++;
        if (acc_log[0] !== BOOT_PC || acc_log[1] !== BOOT_PC + 64'd8) begin
            n_fail++; $display("FAIL stream_addr got=%h,%h want=%h,%h", acc_log[0], acc_log[1], BOOT_PC, BOOT_PC + 64'd8);
        end
        n_cmp++;
        if (dlv_pc[0] !== BOOT_PC || dlv_mask[0] !== 2'b11) begin
            n_fail++; $display("FAIL stream_blk got=%h/%b want=%h/11", dlv_pc[0], dlv_mask[0], BOOT_PC);
        end
    endtask

    task automatic test_ready_low();
        drain();
        lat_min = 1; lat_max = 1;
        step(0, 1, 64'h8000_0010, 1);
        acc_log.delete();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            n_cmp++;
            if (obs_stall !== 1'b1 || obs_addr !== 64'h8000_0010) begin
                n_fail++; $display("FAIL ready_low_hold got stall=%b addr=%h want 1/80000010", obs_stall, obs_addr);
            end
        end
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        n_cmp++;
        if (acc_log.size() != 1 || acc_log[0] !== 64'h8000_0010) begin
            n_fail++; $display("FAIL ready_low_accept got n=%0d addr=%h want 1/80000010", acc_log.size(), acc_log[0]);
        end
    endtask

    task automatic test_redirect();
        drain();
        lat_min = 3; lat_max = 3;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        n_cmp++;
        if (acc_log.size() != 2) begin
            n_fail++; $display("FAIL redirect_setup got=%0d want=2", acc_log.size());
        end
        step(0, 1, 64'h8000_0104, 1);
        lat_min = 1; lat_max = 1;
        acc_log.delete(); dlv_pc.delete(); dlv_mask.delete();
        repeat (10) step(1, 0, 0, 1);
        n_cmp++;
        if (acc_log[0] !== 64'h8000_0100) begin
            n_fail++; $display("FAIL redirect_addr got=%h want=80000100", acc_log[0]);
        end
        n_cmp++;
        if (dlv_pc[0] !== 64'h8000_0104 || dlv_mask[0] !== 2'b10) begin
            n_fail++; $display("FAIL redirect_blk got=%h/%b want=80000104/10", dlv_pc[0], dlv_mask[0]);
        end
    endtask

    task automatic test_ibuf_stall();
        logic [63:0] p0;
        drain();
        lat_min = 1; lat_max = 1;
        p0 = cpc;
        repeat (10) step(1, 0, 0, 0);
        n_cmp++;
        if (obs_rv !== 1'b0 || obs_stall !== 1'b1 || acc_log.size() != 2) begin
            n_fail++; $display("FAIL ibuf_full got rv=%b stall=%b acc=%0d want 0/1/2", obs_rv, obs_stall, acc_log.size());
        end
        repeat (10) step(0, 0, 0, 1);
        n_cmp++;
        if (dlv_pc.size() != 2 || dlv_pc[0] !== p0 || dlv_pc[1] !== {p0[63:3], 3'b000} + 64'd8) begin
            n_fail++; $display("FAIL ibuf_order got n=%0d %h,%h want 2 %h,%h", dlv_pc.size(), dlv_pc[0], dlv_pc[1],
                               p0, {p0[63:3], 3'b000} + 64'd8);
        end
    endtask

    task automatic test_collide();
        int n = 0;
        drain();
        lat_min = 1; lat_max = 1;
        while (!(sched.size() != 0 && sched[0].due == cyc && expq.size() != 0) && n < 40) begin
            step(1, 0, 0, 0); n++;
        end
        if (n >= 40) begin
            n_cmp++; n_fail++; $display("FAIL collide_timeout cyc=%0d got=no_setup want=setup", cyc);
        end else begin
            step(0, 1, 64'h8000_0200, 1);
            n_cmp++;
            if (obs_stall !== 1'b0 || obs_ibv !== 1'b1) begin
                n_fail++; $display("FAIL collide_cycle got stall=%b ibv=%b want 0/1", obs_stall, obs_ibv);
            end
            step(0, 0, 0, 1);
            n_cmp++;
            if (obs_ibv !== 1'b0) begin
                n_fail++; $display("FAIL collide_flush got ibv=%b want 0", obs_ibv);
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        lat_min = 1; lat_max = 1;
        repeat (6) step(1, 0, 0, 0);
        #2;
        apply_reset();
        check_reset_outputs("mid_reset");
        release_reset();
        repeat (10) step(1, 0, 0, 1);
        n_cmp++;
        if (dlv_pc[0] !== BOOT_PC || dlv_mask[0] !== 2'b11) begin
            n_fail++; $display("FAIL mid_reset_first got=%h/%b want=%h/11", dlv_pc[0], dlv_mask[0], BOOT_PC);
        end
    endtask

    task automatic test_random();
        bit redir;
        logic [63:0] tgt;
        lat_min = 1; lat_max = 3;
        dlv_pc.delete();
        for (int i = 0; i < 600; i++) begin
            redir = ($urandom_range(15, 0) == 0);
            tgt   = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
            step($urandom_range(3, 0) != 0, redir, tgt, $urandom_range(2, 0) != 0);
        end
        n_cmp++;
        if (dlv_pc.size() < 20) begin
            n_fail++; $display("FAIL random_progress got=%0d want>=20", dlv_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_low();
        test_redirect();
        test_ibuf_stall();
        test_collide();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
